// File: rtl/demorgan_equiv_checker.sv
// -----------------------------------------------------------------------------
// demorgan_equiv_checker
//
// Response checker for a two-input De Morgan gate pair. It sweeps {A,B}
// through 00, 01, 10, 11 (PASSES times) and drives the vectors into a device
// under check. For each vector it holds the stimulus for SETTLE_CYCLES, then
// samples the device's two equivalent-form outputs. Both outputs are compared
// against a golden NOR (mode=0) or NAND (mode=1) value. The checker reports
// pass/fail, a saturating mismatch count and the first failing vector.
//
// Ports
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   start       in   1      run request, honoured only in IDLE
//   mode        in   1      0: golden ~(A|B), 1: golden ~(A&B); captured at start
//   a_out       out  1      registered stimulus A
//   b_out       out  1      registered stimulus B
//   resp_x      in   1      device output, form 1
//   resp_y      in   1      device output, form 2
//   busy        out  1      run in progress
//   done        out  1      one-cycle pulse at end of run
//   pass        out  1      zero mismatches; valid from done until next start
//   err_cnt     out  CNT_W  mismatching vectors, saturating
//   fail_vec    out  2      {A,B} of first failing vector
//   fail_valid  out  1      fail_vec holds a captured vector
//
// Handshake: start is a level sampled on the rising edge. It is accepted only
// when the FSM is in IDLE. Otherwise it is ignored. busy rises on the
// accepting edge. done pulses for one cycle on the same edge that drops busy.
// -----------------------------------------------------------------------------
module demorgan_equiv_checker #(
    parameter int SETTLE_CYCLES = 1,
    parameter int PASSES        = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    output logic             a_out,
    output logic             b_out,
    input  logic             resp_x,
    input  logic             resp_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       fail_vec,
    output logic             fail_valid
);

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PC_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [SC_W-1:0]  SC_LAST = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [PC_W-1:0]  PC_LAST = PC_W'(PASSES - 1);
    localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [1:0]       vec_q, vec_d;
    logic [SC_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [PC_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [1:0]       fail_vec_q, fail_vec_d;
    logic             fail_valid_q, fail_valid_d;

    logic             exp_bit;
    logic             mismatch;
    logic             last_vec;
    logic [1:0]       vec_next;

    // Golden value is derived from the registered stimulus actually presented
    // to the device, not from the vector counter.
    assign exp_bit  = mode_q ? ~(a_q & b_q) : ~(a_q | b_q);
    // One mismatch per vector, even when both forms are wrong.
    assign mismatch = (resp_x != exp_bit) || (resp_y != exp_bit);
    assign last_vec = (vec_q == 2'd3) && (pass_cnt_q == PC_LAST);
    assign vec_next = vec_q + 2'd1;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        vec_d        = vec_q;
        settle_cnt_d = settle_cnt_q;
        pass_cnt_d   = pass_cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        err_cnt_d    = err_cnt_q;
        fail_vec_d   = fail_vec_q;
        fail_valid_d = fail_valid_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d       = mode;
                    vec_d        = 2'd0;
                    settle_cnt_d = '0;
                    pass_cnt_d   = '0;
                    err_cnt_d    = '0;
                    fail_valid_d = 1'b0;
                    pass_d       = 1'b0;
                    a_d          = 1'b0;
                    b_d          = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (settle_cnt_q == SC_LAST) begin
                    settle_cnt_d = '0;
                    state_d      = S_SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end

            S_SAMPLE: begin
                if (mismatch) begin
                    if (err_cnt_q != ERR_MAX) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (!fail_valid_q) begin
                        fail_vec_d   = {a_q, b_q};
                        fail_valid_d = 1'b1;
                    end
                end
                if (last_vec) begin
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    state_d = S_DONE;
                end else begin
                    vec_d = vec_next;
                    if (vec_q == 2'd3) begin
                        pass_cnt_d = pass_cnt_q + 1'b1;
                    end
                    a_d     = vec_next[1];
                    b_d     = vec_next[0];
                    state_d = S_SETTLE;
                end
            end

            S_DONE: begin
                // err_cnt_q already includes the final sample of this run.
                done_d  = 1'b1;
                pass_d  = (err_cnt_q == '0);
                busy_d  = 1'b0;
                a_d     = 1'b0;
                b_d     = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mode_q       <= 1'b0;
            vec_q        <= 2'd0;
            settle_cnt_q <= '0;
            pass_cnt_q   <= '0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            fail_vec_q   <= 2'd0;
            fail_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            vec_q        <= vec_d;
            settle_cnt_q <= settle_cnt_d;
            pass_cnt_q   <= pass_cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_cnt_q    <= err_cnt_d;
            fail_vec_q   <= fail_vec_d;
            fail_valid_q <= fail_valid_d;
        end
    end

    assign a_out      = a_q;
    assign b_out      = b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_cnt_q;
    assign fail_vec   = fail_vec_q;
    assign fail_valid = fail_valid_q;

endmodule
